dmem_resp: RTL

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - wait-stated word memory with valid/ready request and response channels
// Byte-lane stores are honoured only when DMEM_RESP_BYTE_WRITE_EN is defined; otherwise every store writes all 32 bits.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LP_DEPTH   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LP_WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          LP_NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [29:0] r_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_write;
  logic [29:0] w_idx;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [3:0]  w_lanes;
  logic [AW-1:0] w_addr;
  logic        w_in_range;
  logic        w_enter_resp;
  logic        w_commit;
  logic [31:0] w_rd;
  logic [31:0] w_load_data;
  logic        w_unused_ok;

  // With no wait states the access happens on the handshake edge itself, so use the live request.
  assign w_write = LP_NO_WAIT ? req_write      : r_write;
  assign w_idx   = LP_NO_WAIT ? req_addr[31:2] : r_idx;
  assign w_wdata = LP_NO_WAIT ? req_wdata      : r_wdata;
  assign w_wstrb = LP_NO_WAIT ? req_wstrb      : r_wstrb;

`ifdef DMEM_RESP_BYTE_WRITE_EN
  assign w_lanes     = w_wstrb;
  assign w_unused_ok = &{1'b0, req_addr[1:0]};
`else
  assign w_lanes     = 4'hF;
  assign w_unused_ok = &{1'b0, req_addr[1:0], w_wstrb};
`endif

  assign w_addr       = w_idx[AW-1:0];
  assign w_in_range   = ({2'b00, w_idx} < LP_DEPTH);
  assign w_enter_resp = ((r_state == S_IDLE) && req_valid && LP_NO_WAIT) ||
                        ((r_state == S_ACCESS) && (r_cnt == 4'd0));
  assign w_commit     = w_enter_resp && w_write && w_in_range;
  assign w_rd         = r_mem[w_addr];
  assign w_load_data  = (w_write || !w_in_range) ? 32'd0 : w_rd;

  // Array is never reset; gating on rst keeps an aborted store from landing.
  always_ff @(posedge clk) begin
    if (rst && w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) begin
          r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // RESP spends its first cycle with resp_valid low, so valid rises WAIT_CYCLES+1 edges after handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_idx        <= 30'd0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_idx       <= req_addr[31:2];
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_req_ready <= 1'b0;
            if (LP_NO_WAIT) begin
              r_state      <= S_RESP;
              r_resp_err   <= !w_in_range;
              r_resp_rdata <= w_load_data;
            end else begin
              r_state <= S_ACCESS;
              r_cnt   <= LP_WAIT_M1;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state      <= S_RESP;
            r_resp_err   <= !w_in_range;
            r_resp_rdata <= w_load_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= 4'd0;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule
